// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared constants and state encoding for the VRAM text scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

  localparam int TEXT_COLS = 60;
  localparam int TEXT_ROWS = 17;
  localparam int CELL_W    = 8;
  localparam int CELL_H    = 16;
  localparam int VRAM_AW   = 10;
  localparam int LCD_W     = 480;
  localparam int LCD_H     = 272;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_buf
// Description : One text row of character codes; single write port and a
//               registered read port that holds its value when not enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf
  import vram_pkg::*;
#(
  parameter int DEPTH = TEXT_COLS,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  // Storage array: only the fetch path writes it and reset leaves it alone.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read mux: new data on an enabled in-range read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re && (32'(raddr) < DEPTH)) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Registered read data, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vram_scanner.sv
`default_nettype none
// ============================================================================
// Module      : vram_scanner
// Description : Prefetches one text row from VRAM into a line buffer at the
//               first scanline of each character row, then serves character
//               code and glyph coordinates for every active pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_scanner #(
  parameter int COLS   = 60,
  parameter int ROWS   = 17,
  parameter int CELL_W = 8,
  parameter int CELL_H = 16,
  parameter int RD_LAT = 1
) (
  input  logic       MEMORY_CLK,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic [8:0] line_y,
  input  logic       pix_en,
  input  logic [8:0] pix_x,
  output logic       v_ceb,
  output logic [9:0] v_adb,
  output logic       v_oce,
  output logic       v_resetb,
  input  logic [7:0] v_dout,
  output logic [7:0] char_code,
  output logic [3:0] glyph_row,
  output logic [2:0] glyph_col,
  output logic       char_valid,
  output logic       fetch_busy,
  output logic       fetch_err
);

  import vram_pkg::*;

  localparam int              CW         = $clog2(COLS);
  localparam int              XB         = $clog2(CELL_W);
  localparam int              YB         = $clog2(CELL_H);
  localparam int              DW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [8:0]      Y_LIMIT    = 9'(ROWS * CELL_H);
  localparam logic [8:0]      X_LIMIT    = 9'(COLS * CELL_W);
  localparam logic [CW-1:0]   LAST_COL   = CW'(COLS - 1);
  localparam logic [DW-1:0]   LAST_DRAIN = DW'(RD_LAT - 1);

  // Row base address from a table of constant products: no multiplier.
  function automatic logic [VRAM_AW-1:0] row_base(input logic [8:0] row);
    logic [VRAM_AW-1:0] b;
    b = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row == 9'(i)) b = VRAM_AW'(i * COLS);
    end
    return b;
  endfunction

  scan_state_t        state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [VRAM_AW-1:0] base_q, base_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               dl_vld_q [RD_LAT];
  logic               dl_vld_d [RD_LAT];
  logic [CW-1:0]      dl_idx_q [RD_LAT];
  logic [CW-1:0]      dl_idx_d [RD_LAT];
  logic [3:0]         row_q, row_d;
  logic               char_valid_q, char_valid_d;
  logic [3:0]         glyph_row_q, glyph_row_d;
  logic [2:0]         glyph_col_q, glyph_col_d;
  logic               fetch_err_q, fetch_err_d;

  logic               line_ok;
  logic               pf_start;
  logic               busy;
  logic               pix_ok;
  logic               wr_en;
  logic [CW-1:0]      rd_addr;

  // Qualify the line pulse and pixel strobe against the visible area.
  always_comb begin
    line_ok  = line_start && (line_y < Y_LIMIT);
    pf_start = line_ok && (line_y[YB-1:0] == '0);
    busy     = (state_q != IDLE);
    pix_ok   = pix_en && (pix_x < X_LIMIT);
  end

  // Prefetch FSM next state; a new row start always wins, even mid-fetch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    base_d  = base_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FETCH: begin
        if (col_q == LAST_COL) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pf_start) begin
      state_d = FETCH;
      col_d   = '0;
      base_d  = row_base(line_y >> YB);
    end
  end

  // Read-return delay line; a restart flushes reads still in flight.
  always_comb begin
    for (int i = 0; i < RD_LAT; i++) begin
      dl_vld_d[i] = 1'b0;
      dl_idx_d[i] = '0;
    end
    if (!pf_start) begin
      dl_vld_d[0] = (state_q == FETCH);
      dl_idx_d[0] = col_q;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld_d[i] = dl_vld_q[i-1];
        dl_idx_d[i] = dl_idx_q[i-1];
      end
    end
  end

  // Pixel-side registers, row latch and sticky protocol error.
  always_comb begin
    row_d        = line_ok ? line_y[3:0] : row_q;
    char_valid_d = pix_ok;
    glyph_row_d  = pix_ok ? row_q : glyph_row_q;
    glyph_col_d  = pix_ok ? pix_x[2:0] : glyph_col_q;
    fetch_err_d  = fetch_err_q | (busy && (pf_start || pix_en));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      base_q       <= '0;
      drain_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_idx_q[i] <= '0;
      end
      row_q        <= '0;
      char_valid_q <= 1'b0;
      glyph_row_q  <= '0;
      glyph_col_q  <= '0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      base_q       <= base_d;
      drain_q      <= drain_d;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_d[i];
        dl_idx_q[i] <= dl_idx_d[i];
      end
      row_q        <= row_d;
      char_valid_q <= char_valid_d;
      glyph_row_q  <= glyph_row_d;
      glyph_col_q  <= glyph_col_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Returned data lands in the column it was issued for, unless discarded.
  assign wr_en   = dl_vld_q[RD_LAT-1] && !pf_start;
  assign rd_addr = CW'(pix_x >> XB);

  line_buf #(
    .DEPTH (COLS),
    .AW    (CW)
  ) u_line_buf (
    .clk   (MEMORY_CLK),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (dl_idx_q[RD_LAT-1]),
    .wdata (v_dout),
    .re    (pix_ok),
    .raddr (rd_addr),
    .rdata (char_code)
  );

  assign v_ceb      = (state_q == FETCH);
  assign v_adb      = v_ceb ? (base_q + {{(VRAM_AW-CW){1'b0}}, col_q}) : '0;
  assign v_oce      = 1'b1;
  assign v_resetb   = 1'b0;
  assign glyph_row  = glyph_row_q;
  assign glyph_col  = glyph_col_q;
  assign char_valid = char_valid_q;
  assign fetch_busy = busy;
  assign fetch_err  = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_scanner
// Description : Self-checking bench for vram_scanner with a VRAM whose word k
//               holds k[7:0], a cycle-level reference model and directed
//               vectors with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] line_y = '0;
  logic       pix_en = 1'b0;
  logic [8:0] pix_x = '0;
  logic       v_ceb;
  logic [9:0] v_adb;
  logic       v_oce;
  logic       v_resetb;
  logic [7:0] v_dout = '0;
  logic [7:0] char_code;
  logic [3:0] glyph_row;
  logic [2:0] glyph_col;
  logic       char_valid;
  logic       fetch_busy;
  logic       fetch_err;

  int n_pass  = 0;
  int n_total = 0;

  vram_scanner #(
    .COLS   (60),
    .ROWS   (17),
    .CELL_W (8),
    .CELL_H (16),
    .RD_LAT (1)
  ) dut (
    .MEMORY_CLK (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line_y     (line_y),
    .pix_en     (pix_en),
    .pix_x      (pix_x),
    .v_ceb      (v_ceb),
    .v_adb      (v_adb),
    .v_oce      (v_oce),
    .v_resetb   (v_resetb),
    .v_dout     (v_dout),
    .char_code  (char_code),
    .glyph_row  (glyph_row),
    .glyph_col  (glyph_col),
    .char_valid (char_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // VRAM: one-cycle read, word k holds k[7:0].
  always @(posedge clk) begin
    if (v_ceb) v_dout <= v_adb[7:0];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // m_t: position inside a prefetch (0..59 issue cycles, 60 = settle), -1 idle.
  int         m_t = -1;
  int         m_base = 0;
  bit         m_pend = 0;
  int         m_pcol = 0;
  logic [7:0] m_pdata = '0;
  logic [7:0] m_buf [60];
  bit         m_known [60];
  bit         m_err = 0;
  bit         m_valid = 0;
  logic [7:0] m_code = '0;
  bit         m_code_known = 1;
  logic [3:0] m_row = '0;
  logic [3:0] m_grow = '0;
  logic [2:0] m_gcol = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1; m_pend = 0; m_err = 0; m_valid = 0; m_code = '0;
      m_code_known = 1; m_row = '0; m_grow = '0; m_gcol = '0;
    end else begin
      bit busy, issuing, vis, start;
      busy    = (m_t >= 0);
      issuing = (m_t >= 0) && (m_t < 60);
      vis     = line_start && (int'(line_y) < 272);
      start   = vis && (int'(line_y) % 16 == 0);
      m_valid = 0;
      if (pix_en) begin
        if (busy) m_err = 1;
        if (int'(pix_x) < 480) begin
          m_valid      = 1;
          m_code       = m_buf[int'(pix_x) / 8];
          m_code_known = m_known[int'(pix_x) / 8];
          m_grow       = m_row;
          m_gcol       = 3'(int'(pix_x) % 8);
        end
      end
      if (m_pend && !start) begin
        m_buf[m_pcol]   = m_pdata;
        m_known[m_pcol] = 1;
      end
      m_pend  = issuing && !start;
      m_pcol  = m_t;
      m_pdata = 8'(m_base + m_t);
      if (vis) m_row = 4'(int'(line_y) % 16);
      if (start) begin
        if (busy) m_err = 1;
        m_t    = 0;
        m_base = (int'(line_y) / 16) * 60;
      end else if (m_t >= 0) begin
        m_t++;
        if (m_t > 60) m_t = -1;
      end
    end
  end

  // Compare DUT against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("v_ceb", 32'(v_ceb), 32'((m_t >= 0) && (m_t < 60)));
      if ((m_t >= 0) && (m_t < 60)) check("v_adb", 32'(v_adb), 32'(m_base + m_t));
      check("fetch_busy", 32'(fetch_busy), 32'(m_t >= 0));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
      check("char_valid", 32'(char_valid), 32'(m_valid));
      if (m_code_known) check("char_code", 32'(char_code), 32'(m_code));
      check("glyph_row", 32'(glyph_row), 32'(m_grow));
      check("glyph_col", 32'(glyph_col), 32'(m_gcol));
      check("v_oce", 32'(v_oce), 32'd1);
      check("v_resetb", 32'(v_resetb), 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ls(input int y);
    line_start = 1'b1;
    line_y     = 9'(y);
    tick();
    line_start = 1'b0;
  endtask

  task automatic pix(input int x);
    pix_en = 1'b1;
    pix_x  = 9'(x);
    tick();
    pix_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (fetch_busy && n < 200) begin tick(); n++; end
    check(nm, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_adb(input int a, input string nm);
    int n;
    n = 0;
    while (!(v_ceb && (int'(v_adb) == a)) && n < 200) begin tick(); n++; end
    check(nm, 32'(n < 200), 32'd1);
  endtask

  task automatic measure(output int nceb, output int nbusy, output int first, output int last);
    nceb = 0; nbusy = 0; first = -1; last = -1;
    for (int n = 0; n < 200 && fetch_busy; n++) begin
      if (v_ceb) begin
        if (first < 0) first = int'(v_adb);
        last = int'(v_adb);
        nceb++;
      end
      nbusy++;
      tick();
    end
  endtask

  task automatic count_ceb(input int cycles, output int nceb, output int nbusy);
    nceb = 0; nbusy = 0;
    repeat (cycles) begin
      if (v_ceb) nceb++;
      if (fetch_busy) nbusy++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nceb, nbusy, first, last;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_v_ceb", 32'(v_ceb), 32'd0);
    check("rst_v_adb", 32'(v_adb), 32'd0);
    check("rst_char_code", 32'(char_code), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_fetch_busy", 32'(fetch_busy), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Row 2 prefetch
    ls(32);
    measure(nceb, nbusy, first, last);
    check("row2_ceb_cycles", 32'(nceb), 32'd60);
    check("row2_busy_cycles", 32'(nbusy), 32'd61);
    check("row2_first_addr", 32'(first), 32'd120);
    check("row2_last_addr", 32'(last), 32'd179);
    pix(0);
    check("row2_buf0", 32'(char_code), 32'd120);
    pix(472);
    check("row2_buf59", 32'(char_code), 32'd179);

    // Non-prefetch line latches glyph row only
    ls(37);
    check("line37_no_fetch", 32'(fetch_busy), 32'd0);
    pix(17);
    check("px17_code", 32'(char_code), 32'd122);
    check("px17_row", 32'(glyph_row), 32'd5);
    check("px17_col", 32'(glyph_col), 32'd1);
    check("px17_valid", 32'(char_valid), 32'd1);

    // Off-screen pixel
    pix(480);
    check("px480_valid", 32'(char_valid), 32'd0);
    check("px480_code_hold", 32'(char_code), 32'd122);

    // Off-screen line is ignored completely
    ls(272);
    count_ceb(20, nceb, nbusy);
    check("line272_ceb", 32'(nceb), 32'd0);
    check("line272_busy", 32'(nbusy), 32'd0);
    pix(9);
    check("line272_row_kept", 32'(glyph_row), 32'd5);

    // Last text row reaches the top address
    ls(256);
    measure(nceb, nbusy, first, last);
    check("row16_first_addr", 32'(first), 32'd960);
    check("row16_last_addr", 32'(last), 32'd1019);
    pix(472);
    check("row16_buf59", 32'(char_code), 32'd251);
    check("err_clear_before_abort", 32'(fetch_err), 32'd0);

    // Abort row 0 at column 20 with row 1
    ls(0);
    wait_adb(20, "wait_c20");
    line_start = 1'b1;
    line_y     = 9'd16;
    tick();
    line_start = 1'b0;
    check("restart_addr", 32'(v_adb), 32'd60);
    check("restart_ceb", 32'(v_ceb), 32'd1);
    check("restart_err", 32'(fetch_err), 32'd1);
    wait_idle("restart_idle");
    pix(0);
    check("row1_buf0", 32'(char_code), 32'd60);
    pix(160);
    check("row1_buf20", 32'(char_code), 32'd80);
    pix(472);
    check("row1_buf59", 32'(char_code), 32'd119);

    // Asynchronous reset at column 30 of a row 3 prefetch
    ls(48);
    wait_adb(210, "wait_c30");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_v_ceb", 32'(v_ceb), 32'd0);
    check("arst_v_adb", 32'(v_adb), 32'd0);
    check("arst_busy", 32'(fetch_busy), 32'd0);
    check("arst_err", 32'(fetch_err), 32'd0);
    check("arst_valid", 32'(char_valid), 32'd0);
    check("arst_code", 32'(char_code), 32'd0);
    check("arst_grow", 32'(glyph_row), 32'd0);
    check("arst_gcol", 32'(glyph_col), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_ceb(20, nceb, nbusy);
    check("post_rst_ceb", 32'(nceb), 32'd0);
    check("post_rst_busy", 32'(nbusy), 32'd0);
    pix(224);
    check("rst_buf28_written", 32'(char_code), 32'd208);
    pix(232);
    check("rst_buf29_old", 32'(char_code), 32'd89);

    // Pixel during a prefetch flags a protocol error
    ls(64);
    check("pre_pix_err", 32'(fetch_err), 32'd0);
    pix(8);
    check("pix_busy_err", 32'(fetch_err), 32'd1);
    check("pix_busy_valid", 32'(char_valid), 32'd1);
    wait_idle("pix_busy_idle");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
